// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-requester main-memory port arbiter:
//   state_t       - arbiter FSM state encoding (2 bits)
//   rd_tag_t      - {valid, owner} tag carried by the read-return pipe
//   BANK_LSB      - lowest address bit of the bank select field
//   NUM_BANKS     - number of memory banks reporting busy
//   bank_conflict - true when the addressed bank or the whole memory is stalled
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int BANK_LSB  = 1;
  localparam int NUM_BANKS = 4;
  localparam int BANK_W    = $clog2(NUM_BANKS);

  typedef struct packed {
    logic valid;
    logic owner;  // 0: data cache, 1: instruction cache
  } rd_tag_t;

  function automatic logic bank_conflict(input logic [NUM_BANKS-1:0] busy,
                                         input logic [BANK_W-1:0]    bank,
                                         input logic                 stall);
    return busy[bank] | stall;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the two cache-controller request ports and the memory-side port of
// the arbiter.
//   req/rd/wr/addr/wdata 0,1 - requester handshake (0: dcache, 1: icache)
//   gnt/ack/rvalid 0,1, err  - arbiter responses to the requesters
//   mem_addr/wdata/rd/wr     - forwarded memory access
//   busy, stall              - memory back-pressure
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (caches + memory)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = 16
);

  logic                 req0, rd0, wr0;
  logic [AW-1:0]        addr0, wdata0;
  logic                 req1, rd1, wr1;
  logic [AW-1:0]        addr1, wdata1;

  logic                 gnt0, gnt1;
  logic                 ack0, ack1;
  logic                 rvalid0, rvalid1;
  logic                 err;

  logic [AW-1:0]        mem_addr;
  logic [AW-1:0]        mem_wdata;
  logic                 mem_rd, mem_wr;
  logic [NUM_BANKS-1:0] busy;
  logic                 stall;

  modport slave (
    input  req0, rd0, wr0, addr0, wdata0,
    input  req1, rd1, wr1, addr1, wdata1,
    input  busy, stall,
    output gnt0, gnt1, ack0, ack1, rvalid0, rvalid1, err,
    output mem_addr, mem_wdata, mem_rd, mem_wr
  );

  modport master (
    output req0, rd0, wr0, addr0, wdata0,
    output req1, rd1, wr1, addr1, wdata1,
    output busy, stall,
    input  gnt0, gnt1, ack0, ack1, rvalid0, rvalid1, err,
    input  mem_addr, mem_wdata, mem_rd, mem_wr
  );

endinterface

// File: rtl/rd_tag_pipe.sv
// -----------------------------------------------------------------------------
// rd_tag_pipe
// DEPTH-stage shift register of {valid, owner} tags, one entry loaded per
// cycle. The tail stage lines up with the memory's read data, so the tail tag
// says whether that data is valid and which requester it belongs to.
//   clk, rst         - clock, synchronous active-high reset
//   i_valid, i_owner - tag entering stage 0 (read issued this cycle, by whom)
//   o_valid, o_owner - tag at the tail stage
//   o_empty          - no valid tag anywhere in the pipe
// -----------------------------------------------------------------------------
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic i_owner,
  output logic o_valid,
  output logic o_owner,
  output logic o_empty
);

  rd_tag_t [DEPTH-1:0] r_pipe;
  logic                w_any_valid;

  // NOTE: this storage is reset on purpose: clearing it is how in-flight reads
  // are dropped on reset, so no stale rvalid can escape afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a shift register.
      r_pipe[0] <= '{valid: i_valid, owner: i_owner};
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  // NOTE: default first, so the reduction never holds a value across
  // evaluations and no latch is inferred.
  always_comb begin
    w_any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_any_valid = w_any_valid | r_pipe[i].valid;
    end
  end

  assign o_valid = r_pipe[DEPTH-1].valid;
  assign o_owner = r_pipe[DEPTH-1].owner;
  assign o_empty = ~w_any_valid;

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one four-banked main-memory port between the data cache (requester 0)
// and the instruction cache (requester 1). A requester owns the port for a
// whole burst; each access inside the burst is issued only when its bank is
// free and memory is not stalled. Reads are tagged with their owner and the
// returning rvalid is steered back RD_LAT cycles later. On release, the port
// drains outstanding reads before it can be granted again.
//   clk, rst - clock, synchronous active-high reset
//   bus      - slave side of mem_port_arbiter_if (requesters + memory)
// Parameters:
//   RD_LAT - cycles from accepted mem_rd to read data (1..4)
//   AW     - address / data width
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int AW     = 16
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  state_t              r_state, w_next_state;
  logic                r_last_gnt, w_next_last_gnt;

  logic                w_own;
  logic                w_owner;
  logic                w_req, w_rd, w_wr;
  logic [AW-1:0]       w_addr, w_wdata;
  logic [BANK_W-1:0]   w_bank;
  logic                w_conflict;
  logic                w_issue_rd, w_issue_wr, w_err;
  logic                w_pipe_empty, w_tail_valid, w_tail_owner;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= 1'b1;  // requester 0 wins the first tie
    end else begin
      r_state    <= w_next_state;
      r_last_gnt <= w_next_last_gnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state    = r_state;
    w_next_last_gnt = r_last_gnt;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.req0 && bus.req1) begin
          // Tie goes to whoever did not own the port last.
          w_next_state    = r_last_gnt ? ST_OWN0 : ST_OWN1;
          w_next_last_gnt = ~r_last_gnt;
        end else if (bus.req0) begin
          w_next_state    = ST_OWN0;
          w_next_last_gnt = 1'b0;
        end else if (bus.req1) begin
          w_next_state    = ST_OWN1;
          w_next_last_gnt = 1'b1;
        end
      end
      // With req low no read can issue this cycle, so the pipe's own empty
      // flag already tells whether anything is still in flight.
      ST_OWN0: begin
        if (!bus.req0) w_next_state = w_pipe_empty ? ST_IDLE : ST_DRAIN;
      end
      ST_OWN1: begin
        if (!bus.req1) w_next_state = w_pipe_empty ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_pipe_empty) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Owner mux; everything forwarded is forced to 0 when nobody owns the port
  // ---------------------------------------------------------------------------
  always_comb begin
    w_own   = (r_state == ST_OWN0) || (r_state == ST_OWN1);
    w_owner = (r_state == ST_OWN1);
    w_req   = 1'b0;
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    if (w_own) begin
      if (w_owner) begin
        w_req   = bus.req1;
        w_rd    = bus.rd1;
        w_wr    = bus.wr1;
        w_addr  = bus.addr1;
        w_wdata = bus.wdata1;
      end else begin
        w_req   = bus.req0;
        w_rd    = bus.rd0;
        w_wr    = bus.wr0;
        w_addr  = bus.addr0;
        w_wdata = bus.wdata0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bank gating and issue
  // ---------------------------------------------------------------------------
  assign w_bank     = w_addr[BANK_LSB +: BANK_W];
  assign w_conflict = bank_conflict(bus.busy, w_bank, bus.stall);

  // A simultaneous rd+wr is a requester bug: flag it and issue neither.
  assign w_issue_rd = w_own & w_req & w_rd & ~w_wr & ~w_conflict;
  assign w_issue_wr = w_own & w_req & w_wr & ~w_rd & ~w_conflict;
  assign w_err      = w_own & w_rd & w_wr;

  // ---------------------------------------------------------------------------
  // Read-return routing
  // ---------------------------------------------------------------------------
  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_issue_rd),
    .i_owner (w_owner),
    .o_valid (w_tail_valid),
    .o_owner (w_tail_owner),
    .o_empty (w_pipe_empty)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.gnt0      = (r_state == ST_OWN0);
  assign bus.gnt1      = (r_state == ST_OWN1);
  assign bus.ack0      = (w_issue_rd | w_issue_wr) & ~w_owner;
  assign bus.ack1      = (w_issue_rd | w_issue_wr) &  w_owner;
  assign bus.err       = w_err;
  assign bus.mem_addr  = w_addr;
  assign bus.mem_wdata = w_wdata;
  assign bus.mem_rd    = w_issue_rd;
  assign bus.mem_wr    = w_issue_wr;
  assign bus.rvalid0   = w_tail_valid & ~w_tail_owner;
  assign bus.rvalid1   = w_tail_valid &  w_tail_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with RD_LAT = 2, AW = 16. Inputs change
// 1 ns after the rising edge; outputs are sampled 1 ns later in the same cycle.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int RD_LAT = 2;
  localparam int AW     = 16;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter_if #(.AW(AW)) bus ();

  mem_port_arbiter #(
    .RD_LAT (RD_LAT),
    .AW     (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0 = 0; bus.rd0 = 0; bus.wr0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.rd1 = 0; bus.wr1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    bus.busy = '0; bus.stall = 0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // All single-bit outputs packed together; must be zero after reset.
  function automatic logic [8:0] flags();
    return {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.rvalid0, bus.rvalid1,
            bus.err, bus.mem_rd, bus.mem_wr};
  endfunction

  initial begin
    clear_inputs();
    rst = 1'b1;
    step();
    #1;
    check("rst_flags", 32'(flags()), 32'h0);
    check("rst_addr", 32'(bus.mem_addr), 32'h0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'h0);
    step();
    rst = 1'b0;

    // ---- 1: single read from requester 1 ------------------------------------
    bus.req1 = 1; bus.rd1 = 1; bus.addr1 = 16'h1A04;
    #1;
    check("t1_idle_gnt1", 32'(bus.gnt1), 32'd0);
    check("t1_idle_rd", 32'(bus.mem_rd), 32'd0);
    step();
    #1;
    check("t1_gnt1", 32'(bus.gnt1), 32'd1);
    check("t1_mem_rd", 32'(bus.mem_rd), 32'd1);
    check("t1_mem_addr", 32'(bus.mem_addr), 32'h1A04);
    check("t1_ack1", 32'(bus.ack1), 32'd1);
    check("t1_ack0", 32'(bus.ack0), 32'd0);
    step();
    bus.rd1 = 0;
    #1;
    check("t1_rvalid1_early", 32'(bus.rvalid1), 32'd0);
    step();
    #1;
    check("t1_rvalid1", 32'(bus.rvalid1), 32'd1);
    check("t1_rvalid0", 32'(bus.rvalid0), 32'd0);
    step();
    bus.req1 = 0;
    #1;
    check("t1_rvalid1_late", 32'(bus.rvalid1), 32'd0);
    step();
    #1;
    check("t1_release", 32'(bus.gnt1), 32'd0);

    // ---- 2: tie after reset, burst, drain, alternation ---------------------
    reset_dut();
    bus.req0 = 1; bus.req1 = 1;
    step();
    #1;
    check("t2_tie_gnt0", 32'(bus.gnt0), 32'd1);
    check("t2_tie_gnt1", 32'(bus.gnt1), 32'd0);
    for (int k = 0; k < 4; k++) begin
      bus.rd0   = 1;
      bus.addr0 = 16'h0100 + 16'(2 * k);
      #1;
      check($sformatf("t2_burst_ack%0d", k), 32'(bus.ack0), 32'd1);
      check($sformatf("t2_burst_addr%0d", k), 32'(bus.mem_addr), 32'(16'h0100 + 16'(2 * k)));
      step();
    end
    bus.req0 = 0; bus.rd0 = 0;
    #1;
    check("t2_rel_gnt0", 32'(bus.gnt0), 32'd1);
    check("t2_rel_ack0", 32'(bus.ack0), 32'd0);
    check("t2_rel_rvalid0", 32'(bus.rvalid0), 32'd1);
    step();
    #1;
    check("t2_drain1_gnt", 32'({bus.gnt0, bus.gnt1}), 32'd0);
    check("t2_drain1_rvalid0", 32'(bus.rvalid0), 32'd1);
    step();
    #1;
    check("t2_drain2_gnt", 32'({bus.gnt0, bus.gnt1}), 32'd0);
    check("t2_drain2_rvalid0", 32'(bus.rvalid0), 32'd0);
    step();
    #1;
    check("t2_idle_gnt1", 32'(bus.gnt1), 32'd0);
    step();
    #1;
    check("t2_next_gnt1", 32'(bus.gnt1), 32'd1);
    step();
    bus.req1 = 0;
    step();
    bus.req0 = 1; bus.req1 = 1;
    step();
    #1;
    check("t2_alt_gnt0", 32'(bus.gnt0), 32'd1);
    check("t2_alt_gnt1", 32'(bus.gnt1), 32'd0);
    step();
    bus.req0 = 0; bus.req1 = 0;
    step();

    // ---- 3: bank busy and global stall gating ------------------------------
    bus.req0 = 1; bus.rd0 = 1; bus.addr0 = 16'h0006; bus.busy = 4'b1000;
    step();
    #1;
    check("t3_gnt0", 32'(bus.gnt0), 32'd1);
    check("t3_busy_rd", 32'(bus.mem_rd), 32'd0);
    check("t3_busy_ack", 32'(bus.ack0), 32'd0);
    step();
    bus.busy = 4'b0000;
    #1;
    check("t3_free_rd", 32'(bus.mem_rd), 32'd1);
    check("t3_free_ack", 32'(bus.ack0), 32'd1);
    check("t3_free_addr", 32'(bus.mem_addr), 32'h0006);
    step();
    bus.addr0 = 16'h000E; bus.stall = 1;
    #1;
    check("t3_stall_rd", 32'(bus.mem_rd), 32'd0);
    check("t3_stall_ack", 32'(bus.ack0), 32'd0);
    step();
    bus.stall = 0;
    #1;
    check("t3_unstall_ack", 32'(bus.ack0), 32'd1);
    check("t3_rvalid0", 32'(bus.rvalid0), 32'd1);
    step();
    bus.addr0 = 16'h0006; bus.busy = 4'b0111;
    #1;
    check("t3_other_busy_ack", 32'(bus.ack0), 32'd1);
    step();
    bus.rd0 = 0; bus.req0 = 0; bus.busy = 4'b0000;
    for (int k = 0; k < 4; k++) step();

    // ---- 4: rd+wr together from the owner ----------------------------------
    bus.req1 = 1; bus.rd1 = 1; bus.wr1 = 1; bus.addr1 = 16'h0010; bus.wdata1 = 16'h5555;
    step();
    #1;
    check("t4_gnt1", 32'(bus.gnt1), 32'd1);
    check("t4_err", 32'(bus.err), 32'd1);
    check("t4_no_issue", 32'({bus.mem_rd, bus.mem_wr, bus.ack1}), 32'd0);
    step();
    #1;
    check("t4_gnt1_held", 32'(bus.gnt1), 32'd1);
    check("t4_err_held", 32'(bus.err), 32'd1);
    step();
    bus.rd1 = 0;
    #1;
    check("t4_err_clear", 32'(bus.err), 32'd0);
    check("t4_wr_issue", 32'(bus.mem_wr), 32'd1);
    check("t4_wr_ack1", 32'(bus.ack1), 32'd1);
    step();
    bus.wr1 = 0; bus.req1 = 0;
    step();

    // ---- 5: writeback burst, release without drain -------------------------
    bus.req0 = 1; bus.wr0 = 1; bus.addr0 = 16'h2000; bus.wdata0 = 16'hA5A0;
    step();
    for (int k = 0; k < 4; k++) begin
      bus.addr0  = 16'h2000 + 16'(2 * k);
      bus.wdata0 = 16'hA5A0 + 16'(k);
      #1;
      check($sformatf("t5_ack%0d", k), 32'(bus.ack0), 32'd1);
      check($sformatf("t5_wr%0d", k), 32'(bus.mem_wr), 32'd1);
      check($sformatf("t5_addr%0d", k), 32'(bus.mem_addr), 32'(16'h2000 + 16'(2 * k)));
      check($sformatf("t5_wdata%0d", k), 32'(bus.mem_wdata), 32'(16'hA5A0 + 16'(k)));
      step();
    end
    bus.req0 = 0; bus.wr0 = 0;
    #1;
    check("t5_rel_gnt0", 32'(bus.gnt0), 32'd1);
    check("t5_rel_wr", 32'(bus.mem_wr), 32'd0);
    step();
    bus.req1 = 1;
    #1;
    check("t5_idle_gnt0", 32'(bus.gnt0), 32'd0);
    step();
    #1;
    check("t5_no_drain_gnt1", 32'(bus.gnt1), 32'd1);
    step();
    bus.req1 = 0;
    step();

    // ---- 6: reset right after a read issue ---------------------------------
    bus.req0 = 1; bus.rd0 = 1; bus.addr0 = 16'h0040;
    step();
    #1;
    check("t6_ack0", 32'(bus.ack0), 32'd1);
    step();
    rst = 1; bus.rd0 = 0; bus.req0 = 0;
    step();
    rst = 0; bus.req0 = 1; bus.req1 = 1;
    #1;
    check("t6_flags", 32'(flags()), 32'h0);
    check("t6_addr", 32'(bus.mem_addr), 32'h0);
    check("t6_rvalid0", 32'(bus.rvalid0), 32'd0);
    step();
    #1;
    check("t6_tie_gnt0", 32'(bus.gnt0), 32'd1);
    check("t6_tie_gnt1", 32'(bus.gnt1), 32'd0);
    check("t6_rvalid0_late", 32'(bus.rvalid0), 32'd0);
    bus.req0 = 0; bus.req1 = 0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single four-banked main memory port (mem_addr / mem_rd / mem_wr, busy[3:0], stall) between two cache controllers: requester 0 is the data cache and requester 1 is the instruction cache.
- Grants the port for a whole burst (fill or writeback) and gates each access on bank availability.
- Tracks in-flight reads and routes each read-return valid back to the requester that issued it.
- Sits between the cache FSMs and the memory.

Parameters:
- RD_LAT, 2, cycles from an accepted mem_rd to valid read data at the memory output (1..4).
- AW, 16, address / data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0  in  1  requester 0 wants the port; held high for the whole burst
- rd0  in  1  requester 0 read request this cycle
- wr0  in  1  requester 0 write request this cycle
- addr0  in  AW  requester 0 address
- wdata0  in  AW  requester 0 write data
- req1, rd1, wr1, addr1, wdata1  in  1/1/1/AW/AW  same meanings for requester 1
- gnt0, gnt1  out  1  requester owns the port (registered state)
- ack0, ack1  out  1  the rd/wr of this cycle was issued to memory
- rvalid0, rvalid1  out  1  memory read data this cycle belongs to that requester
- err  out  1  rd and wr both high for the owner; no issue happens
- mem_addr  out  AW  forwarded address
- mem_wdata  out  AW  forwarded write data
- mem_rd, mem_wr  out  1  memory strobes
- busy  in  4  per-bank busy from memory
- stall  in  1  global memory stall

Behaviour:
- Reset:
  - State returns to IDLE.
  - last_gnt is set to 1, so requester 0 wins the first tie.
  - The read-tag pipe is cleared; in-flight returns are dropped and raise no rvalid.
  - All outputs are 0; mem_addr and mem_wdata are 0.
- States: IDLE, OWN0, OWN1, DRAIN, with a 2-bit encoding.
- IDLE:
  - No memory access is issued.
  - req0 & req1 → OWN(~last_gnt).
  - Only one req high → that requester's OWN state.
  - No req → stay in IDLE.
  - last_gnt updates on the transition.
  - Grant is visible the cycle after the request; minimum latency from req to first ack is 1 cycle.
- OWNx:
  - gntx = 1. mem_addr = addrx and mem_wdata = wdatax, combinationally.
  - bank = addrx[2:1]. conflict = busy[bank] | stall.
  - mem_rd = reqx & rdx & ~wrx & ~conflict.
  - mem_wr = reqx & wrx & ~rdx & ~conflict.
  - ackx = mem_rd | mem_wr. The requester holds rd/wr until it sees ack.
  - rdx & wrx → err = 1, nothing is issued, state is unchanged.
  - reqx low → DRAIN if reads are outstanding (any pipe valid bit set, counting a read issued this cycle, which cannot happen while reqx is low), otherwise IDLE.
  - The other requester's req is ignored while in OWNx; there is no preemption.
- DRAIN:
  - No issue; gnt0 = gnt1 = 0.
  - Stay until the pipe is empty, then go to IDLE.
  - Guarantees that rvalid is never misrouted across ownership changes.
- Read-tag pipe:
  - RD_LAT-deep shift register of {valid, owner}.
  - Stage 0 loads {mem_rd, owner} every cycle.
  - At the tail: rvalid0 = valid & ~owner; rvalid1 = valid & owner.
  - Combinational from the register tail, so rvalid occurs exactly RD_LAT cycles after ack.
- Writes are fire-and-forget and are not tracked.
- Starvation bound: each grant lasts one burst; the other requester is served next whenever both are pending.
- Simultaneous events:
  - Release and new req in the same cycle → pass through IDLE (one dead cycle) before the new grant.
  - Reset dominates all events.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding constants ST_IDLE, ST_OWN0, ST_OWN1, ST_DRAIN
  - BANK_LSB = 1, NUM_BANKS = 4
- One natural sub-module, rd_tag_pipe, holding the parameterised {valid, owner} shift register plus its empty flag.
- The top level holds the FSM, the mux, and the bank-conflict gating.

Test Plan:
1. Idle, then req1 = 1, rd1 = 1, addr1 = 0x1A04, busy = 0 → gnt1 next cycle, mem_rd = 1 with mem_addr = 0x1A04, ack1 = 1; rvalid1 exactly RD_LAT = 2 cycles later.
2. req0 and req1 both rise in the same cycle after reset → gnt0 first. Requester 0 releases after a 4-read burst → DRAIN for 2 cycles, then IDLE, then gnt1. Both re-request → gnt0 again (alternation).
3. Owner 0, addr0 = 0x0006 (bank 3), busy = 4'b1000 → mem_rd = 0, ack0 = 0. busy clears → issue the same cycle; the same happens with stall = 1 then 0.
4. Owner 1: rd1 = wr1 = 1 → err = 1, mem_rd = mem_wr = 0, gnt1 stays 1.
5. Owner 0 writeback: 4 writes to 0x2000, 0x2002, 0x2004, 0x2006 with busy = 0 → 4 consecutive acks, mem_wdata matches wdata0. Release → IDLE directly, no DRAIN.
6. rst asserted one cycle after a read issue → all outputs 0 next cycle, no rvalid ever appears for that read, state IDLE.
